// File: rtl/axi4lite_cpuif_responder.sv
// AXI4-Lite responder bridging to a single-beat cpuif strobe bus.
// Define AXI4LITE_ERR_DECODE_EN to answer addresses >= ADDR_SPAN with SLVERR locally.
module axi4lite_cpuif_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN = 'h1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [1:0]              s_axil_bresp,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int AL = (DATA_WIDTH == 64) ? 3 : 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RESP
    } state_t;

    state_t state, state_nx;

    logic                  aw_held, w_held, ar_held;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;
    logic                  prio_rd;
    logic                  cur_wr;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  wr_pend, rd_pend, pick_wr, issue;
    logic                  sel_wr, sel_ack, sel_err, oob;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  take;
    logic                  unused_ok;

    assign s_axil_awready = !aw_held;
    assign s_axil_wready  = !w_held;
    assign s_axil_arready = !ar_held;

    assign wr_pend = aw_held && w_held;
    assign rd_pend = ar_held;
    assign pick_wr = wr_pend && (!rd_pend || !prio_rd);
    assign issue   = (state == IDLE) && (wr_pend || rd_pend);

    // In IDLE the arbiter picks; afterwards the issued direction is frozen
    assign sel_wr   = (state == IDLE) ? pick_wr : cur_wr;
    assign sel_addr = sel_wr ? aw_addr : ar_addr;
    assign sel_ack  = sel_wr ? cpuif_wr_ack : cpuif_rd_ack;
    assign sel_err  = sel_wr ? cpuif_wr_err : cpuif_rd_err;

`ifdef AXI4LITE_ERR_DECODE_EN
    assign oob       = sel_addr >= ADDR_SPAN;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, sel_addr[AL-1:0]};
`else
    assign oob       = 1'b0;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, sel_addr[AL-1:0], ADDR_SPAN};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cpuif_req = 1'b0;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    if (oob) begin
                        take     = 1'b1;
                        state_nx = RESP;
                    end else begin
                        cpuif_req = 1'b1;
                        if (sel_ack) begin
                            take     = 1'b1;
                            state_nx = RESP;
                        end else begin
                            state_nx = WAIT_ACK;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (sel_ack) begin
                    take     = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (cur_wr ? s_axil_bready : s_axil_rready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            ar_held  <= 1'b0;
            aw_addr  <= '0;
            ar_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            prio_rd  <= 1'b1;
            cur_wr   <= 1'b0;
            resp_err <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (take && sel_wr) begin
                aw_held <= 1'b0;
            end else if (s_axil_awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_addr <= s_axil_awaddr;
            end
            if (take && sel_wr) begin
                w_held <= 1'b0;
            end else if (s_axil_wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (take && !sel_wr) begin
                ar_held <= 1'b0;
            end else if (s_axil_arvalid && !ar_held) begin
                ar_held <= 1'b1;
                ar_addr <= s_axil_araddr;
            end
            if (issue) begin
                cur_wr <= pick_wr;
            end
            // Round-robin only advances when both directions competed
            if (issue && wr_pend && rd_pend) begin
                prio_rd <= !prio_rd;
            end
            if (take) begin
                resp_err <= oob || sel_err;
                if (!sel_wr) begin
                    rdata_q <= oob ? '0 : cpuif_rd_data;
                end
            end
        end
    end

    assign s_axil_bvalid = (state == RESP) && cur_wr;
    assign s_axil_rvalid = (state == RESP) && !cur_wr;
    assign s_axil_bresp  = {s_axil_bvalid && resp_err, 1'b0};
    assign s_axil_rresp  = {s_axil_rvalid && resp_err, 1'b0};
    assign s_axil_rdata  = rdata_q;

    assign cpuif_req_is_wr = sel_wr;
    assign cpuif_addr      = {sel_addr[ADDR_WIDTH-1:AL], {AL{1'b0}}};
    assign cpuif_wr_data   = w_data;

    always_comb begin
        cpuif_wr_biten = '0;
        for (int i = 0; i < SW; i++) begin
            cpuif_wr_biten[i*8 +: 8] = {8{w_strb[i]}};
        end
    end

endmodule

// File: tb/tb_axi4lite_cpuif_responder.sv
// Scoreboard bench for axi4lite_cpuif_responder.
// Automatic cpuif responder checks each request against an expected queue.
module tb_axi4lite_cpuif_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b1;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic        rvalid, rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        req, req_wr;
    logic [31:0] req_addr, req_wdata, req_biten;
    logic        rd_ack = 1'b0, rd_err = 1'b0;
    logic [31:0] rd_data = '0;
    logic        wr_ack = 1'b0, wr_err = 1'b0;

    always #5 clk = ~clk;

    axi4lite_cpuif_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axil_awvalid  (awvalid),
        .s_axil_awready  (awready),
        .s_axil_awaddr   (awaddr),
        .s_axil_awprot   (3'b000),
        .s_axil_wvalid   (wvalid),
        .s_axil_wready   (wready),
        .s_axil_wdata    (wdata),
        .s_axil_wstrb    (wstrb),
        .s_axil_bvalid   (bvalid),
        .s_axil_bready   (bready),
        .s_axil_bresp    (bresp),
        .s_axil_arvalid  (arvalid),
        .s_axil_arready  (arready),
        .s_axil_araddr   (araddr),
        .s_axil_arprot   (3'b000),
        .s_axil_rvalid   (rvalid),
        .s_axil_rready   (rready),
        .s_axil_rdata    (rdata),
        .s_axil_rresp    (rresp),
        .cpuif_req       (req),
        .cpuif_req_is_wr (req_wr),
        .cpuif_addr      (req_addr),
        .cpuif_wr_data   (req_wdata),
        .cpuif_wr_biten  (req_biten),
        .cpuif_rd_ack    (rd_ack),
        .cpuif_rd_err    (rd_err),
        .cpuif_rd_data   (rd_data),
        .cpuif_wr_ack    (wr_ack),
        .cpuif_wr_err    (wr_err)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] biten;
        logic [31:0] rdata;
        logic        err;
    } req_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t b_q[$];
    rsp_t r_q[$];
    req_t cur;
    int   vectors = 0;
    int   errs = 0;
    int   lat = 1;
    int   cnt = 0;
    logic pend = 1'b0;
    logic hold_chk = 1'b1;

    task automatic fire();
        if (cur.wr) begin
            wr_ack = 1'b1;
            wr_err = cur.err;
        end else begin
            rd_ack  = 1'b1;
            rd_err  = cur.err;
            rd_data = cur.rdata;
        end
        pend = 1'b0;
    endtask

    // cpuif side: check each request, ack after lat cycles (0 = same cycle)
    initial begin
        forever begin
            @(negedge clk);
            rd_ack = 1'b0;
            wr_ack = 1'b0;
            rd_err = 1'b0;
            wr_err = 1'b0;
            if (pend && hold_chk) begin
                vectors++;
                if (req_addr !== cur.addr || req_wr !== cur.wr) begin
                    errs++;
                    $display("FAIL req_hold addr=%h wr=%b want addr=%h wr=%b",
                             req_addr, req_wr, cur.addr, cur.wr);
                end
            end
            if (pend && cnt > 0) begin
                cnt--;
                if (cnt == 0) fire();
            end
            if (req) begin
                vectors++;
                if (pend) begin
                    errs++;
                    $display("FAIL req_outstanding got req while waiting");
                end
                if (req_q.size() == 0) begin
                    errs++;
                    $display("FAIL req_unexpected got wr=%b addr=%h want none",
                             req_wr, req_addr);
                    cur = '{wr: req_wr, addr: req_addr, default: '0};
                end else begin
                    cur = req_q.pop_front();
                    if (req_wr !== cur.wr || req_addr !== cur.addr ||
                        (cur.wr && (req_wdata !== cur.wdata ||
                                    req_biten !== cur.biten))) begin
                        errs++;
                        $display("FAIL req_fields got wr=%b a=%h d=%h be=%h want wr=%b a=%h d=%h be=%h",
                                 req_wr, req_addr, req_wdata, req_biten,
                                 cur.wr, cur.addr, cur.wdata, cur.biten);
                    end
                end
                pend = 1'b1;
                cnt  = lat;
                if (lat == 0) fire();
            end
        end
    end

    // B/R response scoreboard
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bvalid && bready) begin
                vectors++;
                if (b_q.size() == 0) begin
                    errs++;
                    $display("FAIL b_unexpected got bresp=%b want none", bresp);
                end else begin
                    e = b_q.pop_front();
                    if (bresp !== e.resp) begin
                        errs++;
                        $display("FAIL bresp got %b want %b", bresp, e.resp);
                    end
                end
            end
            if (rst_n && rvalid && rready) begin
                vectors++;
                if (r_q.size() == 0) begin
                    errs++;
                    $display("FAIL r_unexpected got rdata=%h want none", rdata);
                end else begin
                    e = r_q.pop_front();
                    if (rresp !== e.resp || rdata !== e.data) begin
                        errs++;
                        $display("FAIL rresp_rdata got %b/%h want %b/%h",
                                 rresp, rdata, e.resp, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awvalid = 1'b1;
        awaddr  = a;
        @(negedge clk);
        while (!awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errs++;
            $display("FAIL aw_timeout awready=%b want 1", awready);
        end
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        @(negedge clk);
        while (!wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errs++;
            $display("FAIL w_timeout wready=%b want 1", wready);
        end
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        arvalid = 1'b1;
        araddr  = a;
        @(negedge clk);
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errs++;
            $display("FAIL ar_timeout arready=%b want 1", arready);
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((req_q.size() != 0 || b_q.size() != 0 ||
                r_q.size() != 0 || pend) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            errs++;
            $display("FAIL drain_timeout left req=%0d b=%0d r=%0d want 0",
                     req_q.size(), b_q.size(), r_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({awready, wready, arready} !== 3'b111) begin
            errs++;
            $display("FAIL %s_ready got %b want 111", tag,
                     {awready, wready, arready});
        end
        vectors++;
        if ({bvalid, rvalid, req, req_wr, bresp, rresp} !== 8'h00 ||
            {rdata, req_addr, req_wdata, req_biten} !== 128'h0) begin
            errs++;
            $display("FAIL %s_outs got bv=%b rv=%b req=%b rd=%h a=%h want all 0",
                     tag, bvalid, rvalid, req, rdata, req_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_basic();
        lat = 1;
        req_q.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 1'b0});
        b_q.push_back('{2'b00, 32'h0});
        fork
            send_aw(32'h10);
            begin
                repeat (2) @(posedge clk);
                #1 send_w(32'hDEADBEEF, 4'hF);
            end
        join
        wait_drain();
    endtask

    task automatic test_read_stall();
        int n = 0;
        lat = 1;
        rready = 1'b0;
        req_q.push_back('{1'b0, 32'h14, 32'h0, 32'h0, 32'h12345678, 1'b0});
        r_q.push_back('{2'b00, 32'h12345678});
        send_ar(32'h14);
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 50) begin
            errs++;
            $display("FAIL rvalid_timeout rvalid=%b want 1", rvalid);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rvalid !== 1'b1 || rdata !== 32'h12345678 || rresp !== 2'b00) begin
                errs++;
                $display("FAIL r_stable got rv=%b rd=%h rr=%b want 1/12345678/00",
                         rvalid, rdata, rresp);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 rready = 1'b1;
        wait_drain();
        vectors++;
        if (rvalid !== 1'b0) begin
            errs++;
            $display("FAIL r_drop got rvalid=%b want 0", rvalid);
        end
    endtask

    task automatic test_w_first();
        lat = 1;
        req_q.push_back('{1'b1, 32'h20, 32'hCAFEF00D, 32'h00FF00FF, 32'h0, 1'b0});
        b_q.push_back('{2'b00, 32'h0});
        fork
            send_w(32'hCAFEF00D, 4'h5);
            begin
                @(posedge clk);
                #1 send_aw(32'h23);
            end
        join
        wait_drain();
    endtask

    task automatic test_priority();
        lat = 2;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                req_q.push_back('{1'b0, 32'h100, 32'h0, 32'h0, 32'hA5A50000, 1'b0});
                req_q.push_back('{1'b1, 32'h104, 32'h11112222, 32'hFFFFFFFF, 32'h0, 1'b0});
            end else begin
                req_q.push_back('{1'b1, 32'h104, 32'h11112222, 32'hFFFFFFFF, 32'h0, 1'b0});
                req_q.push_back('{1'b0, 32'h100, 32'h0, 32'h0, 32'hA5A50001, 1'b0});
            end
            b_q.push_back('{2'b00, 32'h0});
            r_q.push_back('{2'b00, (k == 0) ? 32'hA5A50000 : 32'hA5A50001});
            fork
                send_aw(32'h104);
                send_w(32'h11112222, 4'hF);
                send_ar(32'h100);
            join
            wait_drain();
        end
    endtask

    task automatic test_errors();
        lat = 0;
        req_q.push_back('{1'b0, 32'h30, 32'h0, 32'h0, 32'hBAD0BAD0, 1'b1});
        r_q.push_back('{2'b10, 32'hBAD0BAD0});
        send_ar(32'h30);
        wait_drain();
        req_q.push_back('{1'b1, 32'h34, 32'h0000BEEF, 32'h0000FFFF, 32'h0, 1'b1});
        b_q.push_back('{2'b10, 32'h0});
        fork
            send_aw(32'h34);
            send_w(32'h0000BEEF, 4'h3);
        join
        wait_drain();
`ifdef AXI4LITE_ERR_DECODE_EN
        r_q.push_back('{2'b10, 32'h0});
        send_ar(32'h1000);
        wait_drain();
`else
        req_q.push_back('{1'b0, 32'h1000, 32'h0, 32'h0, 32'h55AA55AA, 1'b0});
        r_q.push_back('{2'b00, 32'h55AA55AA});
        send_ar(32'h1000);
        wait_drain();
`endif
        lat = 1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic saw_b = 1'b0;
        lat = 8;
        req_q.push_back('{1'b1, 32'h40, 32'h01020304, 32'hFFFFFFFF, 32'h0, 1'b0});
        fork
            send_aw(32'h40);
            send_w(32'h01020304, 4'hF);
        join
        while (!pend && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!pend) begin
            errs++;
            $display("FAIL mid_req_timeout pend=%b want 1", pend);
        end
        hold_chk = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bvalid) saw_b = 1'b1;
        end
        vectors++;
        if (saw_b || pend) begin
            errs++;
            $display("FAIL late_ack got bvalid_seen=%b ack_pending=%b want 0/0",
                     saw_b, pend);
        end
        hold_chk = 1'b1;
        lat = 1;
        req_q.push_back('{1'b0, 32'h48, 32'h0, 32'h0, 32'h0BADF00D, 1'b0});
        r_q.push_back('{2'b00, 32'h0BADF00D});
        @(posedge clk);
        #1 send_ar(32'h4B);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_stall();
        test_w_first();
        test_priority();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
